// File: rtl/ps2_keycode_decoder_pkg.sv
// ps2_pkg: shared types and scan-code set 2 constants for the PS/2 keyboard
// front end (frame receiver + prefix decoder).
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE   = 3'd0,
    P_E0     = 3'd1,
    P_F0     = 3'd2,
    P_E0F0   = 3'd3,
    P_E1SKIP = 3'd4
  } prefix_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_keycode_decoder_frame_rx.sv
// ps2_frame_rx: synchronises and deglitches the PS/2 lines and deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, reset        system clock, async active-high reset
//   ps2_clk, ps2_data raw asynchronous keyboard lines
//   rx_byte           last received data byte (valid while byte_valid)
//   byte_valid        one-cycle pulse, good frame received
//   frame_err         one-cycle pulse, parity/stop error or timeout abort
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          strb;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  wire clk_s  = clk_sync[1];
  wire data_s = data_sync[1];

  assign rx_byte = shreg;

  // Lines idle high, so synchronisers and filter reset to 1 to avoid a
  // spurious falling edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      strb      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      strb      <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        // FILTER_LEN consecutive samples disagreeing with the filtered level
        filt_cnt <= '0;
        clk_filt <= clk_s;
        strb     <= clk_filt;  // falling edge of filtered clock
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_IDLE || strb) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;

      if (state != RX_IDLE && !strb && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        state     <= RX_IDLE;
      end else if (strb) begin
        case (state)
          RX_IDLE: if (!data_s) begin
            state   <= RX_DATA;
            bit_cnt <= '0;
          end
          RX_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= data_s;
            state <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (data_s && (^{shreg, par})) byte_valid <= 1'b1;
            else                           frame_err  <= 1'b1;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: PS/2 keyboard front end. Receives frames and
// resolves scan-code set 2 prefixes into a 9-bit keyCode plus make/brakee
// strobes.
// Ports:
//   clk, reset        system clock, async active-high reset
//   ps2_clk, ps2_data raw asynchronous keyboard lines
//   keyCode           {E0 seen, scan byte}, held until the next code
//   make, brakee      one-cycle press / release strobes
//   frame_err         one-cycle pulse on a bad or aborted frame
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       frame_err
);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  prefix_state_t pst;
  logic [2:0]    skip_cnt;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pst      <= P_IDLE;
      skip_cnt <= '0;
      keyCode  <= '0;
      make     <= 1'b0;
      brakee   <= 1'b0;
    end else begin
      make   <= 1'b0;
      brakee <= 1'b0;
      if (frame_err) begin
        // a broken frame invalidates any pending prefix
        pst <= P_IDLE;
      end else if (byte_valid) begin
        case (pst)
          P_IDLE: begin
            if (rx_byte == PS2_EXT) pst <= P_E0;
            else if (rx_byte == PS2_BRK) pst <= P_F0;
            else if (rx_byte == PS2_PAUSE) begin
              pst      <= P_E1SKIP;
              skip_cnt <= PS2_PAUSE_SKIP;
            end else if (!is_ignored(rx_byte)) begin
              keyCode <= {1'b0, rx_byte};
              make    <= 1'b1;
            end
          end
          P_E0: begin
            if (rx_byte == PS2_BRK) pst <= P_E0F0;
            else if (rx_byte != PS2_EXT) begin
              keyCode <= {1'b1, rx_byte};
              make    <= 1'b1;
              pst     <= P_IDLE;
            end
          end
          P_F0: begin
            keyCode <= {1'b0, rx_byte};
            brakee  <= 1'b1;
            pst     <= P_IDLE;
          end
          P_E0F0: begin
            keyCode <= {1'b1, rx_byte};
            brakee  <= 1'b1;
            pst     <= P_IDLE;
          end
          P_E1SKIP: begin
            // pause sequence carries no make/break semantics; swallow it
            skip_cnt <= skip_cnt - 1'b1;
            if (skip_cnt == 3'd1) pst <= P_IDLE;
          end
          default: pst <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
module tb_ps2_keycode_decoder;

  localparam int HALF = 20;    // PS/2 half period in clk cycles
  localparam int TO   = 2000;  // shortened timeout for simulation

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] keyCode;
  logic       make, brakee, frame_err;

  int total = 0;
  int passed = 0;
  int make_cnt = 0, brk_cnt = 0, err_cnt = 0, both_cnt = 0;

  ps2_keycode_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyCode(keyCode), .make(make), .brakee(brakee), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of each strobe; a pulse longer than one cycle shows
  // up as an extra count.
  always @(negedge clk) begin
    if (make)          make_cnt <= make_cnt + 1;
    if (brakee)        brk_cnt  <= brk_cnt + 1;
    if (frame_err)     err_cnt  <= err_cnt + 1;
    if (make && brakee) both_cnt <= both_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Send the first nbits of a frame for byte b; bad_par flips parity.
  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    cycles(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 11, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycles(3);
    #1;
    total++;
    if ({keyCode, make, brakee, frame_err} !== 12'h000) begin
      $display("FAIL reset_outputs: got %h want 000", {keyCode, make, brakee, frame_err});
    end else passed++;
    @(negedge clk);
    reset = 1'b0;
    cycles(10);
  endtask

  task automatic test_make;
    int m0, b0, e0;
    m0 = make_cnt; b0 = brk_cnt; e0 = err_cnt;
    send(8'h70);
    cycles(20);
    total++;
    if (keyCode !== 9'h070) $display("FAIL make70_code: got %h want 070", keyCode);
    else passed++;
    total++;
    if (make_cnt - m0 !== 1) $display("FAIL make70_pulse: got %0d want 1", make_cnt - m0);
    else passed++;
    total++;
    if ((brk_cnt - b0) + (err_cnt - e0) !== 0)
      $display("FAIL make70_other: got %0d want 0", (brk_cnt - b0) + (err_cnt - e0));
    else passed++;
  endtask

  task automatic test_break;
    int m0, b0;
    m0 = make_cnt; b0 = brk_cnt;
    send(8'hF0);
    cycles(20);
    total++;
    if (make_cnt - m0 !== 0 || brk_cnt - b0 !== 0)
      $display("FAIL brk_prefix_quiet: got make %0d brk %0d want 0 0", make_cnt - m0, brk_cnt - b0);
    else passed++;
    send(8'h70);
    cycles(20);
    total++;
    if (keyCode !== 9'h070 || brk_cnt - b0 !== 1 || make_cnt - m0 !== 0)
      $display("FAIL brk70: got code %h brk %0d make %0d want 070 1 0", keyCode, brk_cnt - b0, make_cnt - m0);
    else passed++;
  endtask

  task automatic test_extended;
    int m0, b0;
    m0 = make_cnt; b0 = brk_cnt;
    send(8'hE0); send(8'h75);
    cycles(20);
    total++;
    if (keyCode !== 9'h175 || make_cnt - m0 !== 1 || brk_cnt - b0 !== 0)
      $display("FAIL ext_make: got code %h make %0d brk %0d want 175 1 0", keyCode, make_cnt - m0, brk_cnt - b0);
    else passed++;
    send(8'hE0); send(8'hF0); send(8'h75);
    cycles(20);
    total++;
    if (keyCode !== 9'h175 || make_cnt - m0 !== 1 || brk_cnt - b0 !== 1)
      $display("FAIL ext_break: got code %h make %0d brk %0d want 175 1 1", keyCode, make_cnt - m0, brk_cnt - b0);
    else passed++;
  endtask

  task automatic test_parity_err;
    int m0, e0;
    m0 = make_cnt; e0 = err_cnt;
    send_frame(8'h16, 11, 1'b1);
    cycles(20);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL parity_err_pulse: got %0d want 1", err_cnt - e0);
    else passed++;
    total++;
    if (keyCode !== 9'h175 || make_cnt - m0 !== 0)
      $display("FAIL parity_err_hold: got code %h make %0d want 175 0", keyCode, make_cnt - m0);
    else passed++;
    send(8'h16);
    cycles(20);
    total++;
    if (keyCode !== 9'h016 || make_cnt - m0 !== 1)
      $display("FAIL parity_recover: got code %h make %0d want 016 1", keyCode, make_cnt - m0);
    else passed++;
  endtask

  task automatic test_timeout;
    int m0, e0;
    m0 = make_cnt; e0 = err_cnt;
    send_frame(8'h69, 5, 1'b0);
    cycles(TO / 2);
    total++;
    if (err_cnt - e0 !== 0) $display("FAIL timeout_early: got %0d want 0", err_cnt - e0);
    else passed++;
    cycles(TO);
    total++;
    if (err_cnt - e0 !== 1 || keyCode !== 9'h016)
      $display("FAIL timeout_abort: got err %0d code %h want 1 016", err_cnt - e0, keyCode);
    else passed++;
    send(8'h69);
    cycles(20);
    total++;
    if (keyCode !== 9'h069 || make_cnt - m0 !== 1)
      $display("FAIL timeout_recover: got code %h make %0d want 069 1", keyCode, make_cnt - m0);
    else passed++;
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    int m0, b0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    m0 = make_cnt; b0 = brk_cnt;
    foreach (seq[i]) send(seq[i]);
    cycles(20);
    total++;
    if (make_cnt - m0 !== 0 || brk_cnt - b0 !== 0 || keyCode !== 9'h069)
      $display("FAIL pause_quiet: got make %0d brk %0d code %h want 0 0 069", make_cnt - m0, brk_cnt - b0, keyCode);
    else passed++;
    send(8'h72);
    cycles(20);
    total++;
    if (keyCode !== 9'h072 || make_cnt - m0 !== 1)
      $display("FAIL pause_then_72: got code %h make %0d want 072 1", keyCode, make_cnt - m0);
    else passed++;
  endtask

  task automatic test_ignored;
    int m0;
    m0 = make_cnt;
    send(8'hAA); send(8'hFA);
    cycles(20);
    total++;
    if (keyCode !== 9'h072 || make_cnt - m0 !== 0)
      $display("FAIL ignored_bytes: got code %h make %0d want 072 0", keyCode, make_cnt - m0);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int m0, b0, e0;
    send_frame(8'h72, 5, 1'b0);
    reset = 1'b1;
    cycles(3);
    #1;
    total++;
    if ({keyCode, make, brakee, frame_err} !== 12'h000)
      $display("FAIL midframe_reset: got %h want 000", {keyCode, make, brakee, frame_err});
    else passed++;
    m0 = make_cnt; b0 = brk_cnt; e0 = err_cnt;
    @(negedge clk);
    reset = 1'b0;
    cycles(TO + 500);
    total++;
    if ((make_cnt - m0) + (brk_cnt - b0) + (err_cnt - e0) !== 0 || keyCode !== 9'h000)
      $display("FAIL midframe_quiet: got pulses %0d code %h want 0 000",
               (make_cnt - m0) + (brk_cnt - b0) + (err_cnt - e0), keyCode);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_make;
    test_break;
    test_extended;
    test_parity_err;
    test_timeout;
    test_pause;
    test_ignored;
    test_reset_midframe;
    total++;
    if (both_cnt !== 0) $display("FAIL make_brakee_overlap: got %0d want 0", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
